u_bitscan: RTL and testbench

- Iterative set-bit scanner; sits directly upstream of the pivot-mask admission stage.
- Accepts a W-bit vector over a valid/ready handshake and emits the index of each set bit, one per handshake.
- Emission order is LSB-first or MSB-first. Each emitted index is the pivot the downstream mask stage evaluates.
- Between emissions, already-emitted bits are cleared from an internal copy of the vector.

---
 rtl/u_bitscan.sv | 67 ++++++
 tb/tb_u_bitscan.sv | 123 ++++++++++++
 2 files changed

// File: rtl/u_bitscan.sv
// u_bitscan: iterative set-bit scanner emitting one index per output handshake.
// Define U_BITSCAN_OVERLAP_EN to accept the next vector on the cycle the final index transfers.
module u_bitscan #(
  parameter int W = 8,
  parameter int LSB = 1,
  localparam int IDXW = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_in_vld,
  input  logic [W-1:0]    i_x,
  output logic            o_in_rdy,
  output logic            o_out_vld,
  input  logic            i_out_rdy,
  output logic [IDXW-1:0] o_idx,
  output logic            o_last
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_n;
  logic [W-1:0] v, v_n, rest;
  logic [IDXW-1:0] idx;
  logic scan, last, in_x, out_x;
  always_comb begin
    idx = '0;
    if (LSB != 0) begin
      for (int i = W - 1; i >= 0; i--) if (v[i]) idx = IDXW'(i);
    end else begin
      for (int i = 0; i < W; i++) if (v[i]) idx = IDXW'(i);
    end
    rest = v;
    rest[idx] = 1'b0;
  end
  assign scan = state == SCAN;
  assign last = rest == '0;
  assign o_out_vld = scan;
  assign o_idx = scan ? idx : '0;
  assign o_last = scan && last;
`ifdef U_BITSCAN_OVERLAP_EN
  assign o_in_rdy = !rst && (!scan || (last && i_out_rdy));
`else
  assign o_in_rdy = !rst && !scan;
`endif
  assign in_x = i_in_vld && o_in_rdy;
  assign out_x = scan && i_out_rdy;
  // A new vector overrides the scan result; only possible on the final transfer when overlapping.
  always_comb begin
    state_n = state;
    v_n = v;
    if (out_x) begin
      v_n = rest;
      state_n = last ? IDLE : SCAN;
    end
    if (in_x) begin
      v_n = i_x;
      state_n = (i_x != '0) ? SCAN : IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      v <= '0;
    end else begin
      state <= state_n;
      v <= v_n;
    end
  end
endmodule

// File: tb/tb_u_bitscan.sv
// tb_u_bitscan: scoreboard bench driving an LSB-first and an MSB-first scanner in lockstep.
module tb_u_bitscan;
  logic clk = 0, rst = 1, i_in_vld = 0, i_out_rdy = 0;
  logic [7:0] i_x = '0;
  logic rdy0, rdy1, vld0, vld1, last0, last1;
  logic [2:0] idx0, idx1;
  int total = 0, bad = 0;
  int q0[$], q1[$];
  always #5 clk = ~clk;

  u_bitscan #(.W(8), .LSB(1)) u0 (.clk(clk), .rst(rst), .i_in_vld(i_in_vld), .i_x(i_x),
    .o_in_rdy(rdy0), .o_out_vld(vld0), .i_out_rdy(i_out_rdy), .o_idx(idx0), .o_last(last0));
  u_bitscan #(.W(8), .LSB(0)) u1 (.clk(clk), .rst(rst), .i_in_vld(i_in_vld), .i_x(i_x),
    .o_in_rdy(rdy1), .o_out_vld(vld1), .i_out_rdy(i_out_rdy), .o_idx(idx1), .o_last(last1));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Queue entries encode index*2 + last flag.
  task automatic push(input logic [7:0] x);
    int ones[$];
    for (int i = 0; i < 8; i++) if ((x >> i) & 1) ones.push_back(i);
    foreach (ones[k]) q0.push_back(ones[k] * 2 + (k == ones.size() - 1 ? 1 : 0));
    for (int k = ones.size() - 1; k >= 0; k--) q1.push_back(ones[k] * 2 + (k == 0 ? 1 : 0));
  endtask

  task automatic cycle(input bit vl, input logic [7:0] x, input bit r);
    @(negedge clk);
    i_in_vld = vl;
    i_x = x;
    i_out_rdy = r;
    #2;
    if (vl && rdy0) push(x);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("vld_in_rst0", vld0, 0);
        chk("vld_in_rst1", vld1, 0);
        chk("rdy_in_rst", rdy0, 0);
      end else begin
        int ev, er;
        ev = q0.size() != 0;
`ifdef U_BITSCAN_OVERLAP_EN
        er = q0.size() == 0 || (q0.size() == 1 && i_out_rdy);
`else
        er = q0.size() == 0;
`endif
        chk("vld0", vld0, ev);
        chk("vld1", vld1, ev);
        chk("rdy0", rdy0, er);
        chk("rdy1", rdy1, er);
        if (vld0 && q0.size() != 0 && q1.size() != 0) begin
          chk("idx_lsb", idx0, q0[0] / 2);
          chk("last_lsb", last0, q0[0] % 2);
          chk("idx_msb", idx1, q1[0] / 2);
          chk("last_msb", last1, q1[0] % 2);
          if (i_out_rdy) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
          end
        end else if (!vld0) begin
          chk("idx_idle", {idx0, idx1}, 0);
          chk("last_idle", {last0, last1}, 0);
        end
      end
    end
  end

  initial begin : driver
    logic [7:0] x;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    cycle(0, 8'h00, 1);
    cycle(1, 8'hA4, 1);
    repeat (4) cycle(0, 8'h00, 1);
    cycle(1, 8'hA4, 1);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 0);
    repeat (4) cycle(0, 8'h00, 1);
    cycle(1, 8'h00, 1);
    cycle(0, 8'h00, 1);
    cycle(1, 8'h10, 1);
    repeat (2) cycle(0, 8'h00, 1);
    cycle(1, 8'h81, 1);
    repeat (3) cycle(0, 8'h00, 1);
    cycle(1, 8'h80, 1);
    repeat (2) cycle(0, 8'h00, 1);
    cycle(1, 8'hA4, 1);
    cycle(0, 8'h00, 1);
    @(negedge clk);
    rst = 1;
    i_in_vld = 0;
    q0.delete();
    q1.delete();
    #3;
    chk("async_rst_vld", vld0, 0);
    @(negedge clk);
    rst = 0;
    repeat (4) cycle(0, 8'h00, 1);
    cycle(1, 8'h01, 1);
    cycle(1, 8'h80, 1);
    repeat (3) cycle(0, 8'h00, 1);
    for (int n = 0; n < 400; n++) begin
      x = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom);
      cycle($urandom % 2 == 1, x, $urandom % 4 != 0);
    end
    for (int n = 0; n < 40 && q0.size() != 0; n++) cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 1);
    chk("drain", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
